// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS HI/LO multiply/divide unit with MTHI/MTLO writes
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [63:0] acc, prod;
  logic [31:0] ma, mb, a_raw, rem_n, quo, rem;
  logic [32:0] sum, rem_sh;
  logic [4:0] cnt;
  logic is_div, div_zero, neg_q, neg_r, sgn, sa, sb, ge;
  always_comb begin
    sgn = op == 3'd0 || op == 3'd2;
    sa = sgn & rs_data[31];
    sb = sgn & rt_data[31];
    sum = {1'b0, acc[63:32]} + (mb[0] ? {1'b0, ma} : 33'd0);
    rem_sh = {acc[63:32], ma[31]};
    ge = rem_sh >= {1'b0, mb};
    rem_n = ge ? rem_sh[31:0] - mb : rem_sh[31:0];
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[31:0] : acc[31:0];
    rem = neg_r ? -acc[63:32] : acc[63:32];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      acc <= '0;
      ma <= '0;
      mb <= '0;
      a_raw <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      div_zero <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (op < 3'd4) begin
            ma <= sa ? -rs_data : rs_data;
            mb <= sb ? -rt_data : rt_data;
            a_raw <= rs_data;
            is_div <= op[1];
            div_zero <= rt_data == 32'd0;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            acc <= '0;
            cnt <= '0;
            state <= CALC;
            busy <= 1'b1;
          end else if (op == 3'd4) hi <= rs_data;
          else if (op == 3'd5) lo <= rs_data;
        end
        CALC: begin
          if (is_div) begin
            acc <= {rem_n, acc[30:0], ge};
            ma <= {ma[30:0], 1'b0};
          end else begin
            acc <= {sum, acc[31:1]};
            mb <= {1'b0, mb[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          hi <= is_div ? (div_zero ? a_raw : rem) : prod[63:32];
          lo <= is_div ? (div_zero ? 32'hFFFF_FFFF : quo) : prod[31:0];
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed self-checking bench against a behavioural HI/LO model
module tb_muldiv_unit;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] rs = '0, rt = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0;
  int rem_cyc = 0;
  logic chk = 1'b0, edone = 1'b0;
  logic [31:0] ehi = '0, elo = '0;
  logic [63:0] stash = '0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs), .rt_data(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: return b == 32'd0 ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      3'd3: return b == 32'd0 ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural model: accepted arithmetic ops resolve 34 cycles after their start cycle
  always @(posedge clk) begin
    edone = 1'b0;
    if (rst) begin
      chk = 1'b1;
      ehi = '0;
      elo = '0;
      rem_cyc = 0;
    end else if (rem_cyc > 0) begin
      rem_cyc--;
      if (rem_cyc == 0) begin
        {ehi, elo} = stash;
        edone = 1'b1;
      end
    end else if (start) begin
      if (op < 3'd4) begin
        stash = ref_res(op, rs, rt);
        rem_cyc = 33;
      end else if (op == 3'd4) ehi = rs;
      else if (op == 3'd5) elo = rs;
    end
  end

  always @(negedge clk) if (chk) begin
    check("busy", 64'(busy), 64'(rem_cyc != 0));
    check("done", 64'(done), 64'(edone));
    check("hi", 64'(hi), 64'(ehi));
    check("lo", 64'(lo), 64'(elo));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    step();
    start = 1'b1;
    op = o;
    rs = a;
    rt = b;
    t0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [31:0] xhi, input logic [31:0] xlo);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check({name, "_lat"}, 64'(cyc - t0), 64'd34);
    check({name, "_hi"}, 64'(hi), 64'(xhi));
    check({name, "_lo"}, 64'(lo), 64'(xlo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    check("pin_mult", ref_res(3'd0, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    check("pin_div", ref_res(3'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("pin_divmin", ref_res(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    check("multu_busy_c1", 64'(busy), 64'd1);
    wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min", 32'h4000_0000, 32'h0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_min", 32'h0, 32'h8000_0000);
    issue(3'd3, 32'd100, 32'd7);
    wait_done("divu", 32'd2, 32'd14);
    issue(3'd3, 32'h1234_5678, 32'd0);
    wait_done("divu_zero", 32'h1234_5678, 32'hFFFF_FFFF);
    issue(3'd3, 32'd100, 32'd7);
    repeat (4) step();
    start = 1'b1;
    op = 3'd4;
    rs = 32'hAAAA_AAAA;
    step();
    op = 3'd1;
    rs = 32'd3;
    rt = 32'd3;
    step();
    start = 1'b0;
    wait_done("busy_ign", 32'd2, 32'd14);
    issue(3'd4, 32'hAAAA_AAAA, 32'd0);
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'hAAAA_AAAA);
    check("mthi_done", 64'(done), 64'd0);
    issue(3'd4, 32'h1111_1111, 32'd0);
    issue(3'd5, 32'h1111_1111, 32'd0);
    issue(3'd1, 32'd5, 32'd5);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    issue(3'd1, 32'd5, 32'd5);
    wait_done("after_rst", 32'd0, 32'h19);
    step();
    rst = 1'b1;
    start = 1'b1;
    op = 3'd4;
    rs = 32'h55;
    step();
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_prio", {32'(busy), hi}, 64'd0);
    for (int i = 0; i < 2500; i++) begin
      step();
      rst = $urandom_range(0, 299) == 0;
      start = $urandom_range(0, 3) == 0;
      op = 3'($urandom_range(0, 7));
      rs = pick();
      rt = pick();
    end
    step();
    rst = 1'b0;
    start = 1'b0;
    repeat (40) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative HI/LO multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file and takes the rs/rt read-data buses as operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles, applies MTHI/MTLO writes, and holds the architectural HI and LO registers. The control path stalls on `busy` and reads results for MFHI/MFLO from the `hi`/`lo` outputs.

## Interface
Parameters:
- none; datapath width is fixed at 32.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `op`  in  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6 and 7 are no-ops.
- `rs_data`  in  32  operand A (multiplicand / dividend / MTHI-MTLO source).
- `rt_data`  in  32  operand B (multiplier / divisor).
- `busy`  out  1  high while an arithmetic operation is in flight.
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold the new result in this cycle.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, FIX.
- **IDLE**
  - `start`=1 with op 0–3: latch operand magnitudes, the sign flags, the op, and divide-by-zero (`rt_data`==0). Clear the 64-bit accumulator and the 5-bit iteration counter, then go to CALC.
  - `start`=1 with op 4: HI <= `rs_data`. Op 5: LO <= `rs_data`. Both complete in the same edge, with no `busy` and no `done`.
  - Ops 6/7: ignored.
- **CALC**: one radix-2 step per cycle for exactly 32 cycles.
  - Multiply: shift-add on the magnitudes.
  - Divide: restoring shift-subtract on the magnitudes.
  - Counter wraps from 31 to 0 on the transition to FIX.
- **FIX**: one cycle.
  - Apply sign correction, write HI/LO, go to IDLE.
- Signed rules (MULT/DIV only; MULTU/DIVU treat operands as unsigned):
  - Product is negated if the operand signs differ. HI:LO = full 64-bit product.
  - Quotient is negative if the signs differ; remainder takes the dividend's sign. LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000, from the magnitude path with no special case.
- Divide by zero (signed or unsigned): LO=0xFFFFFFFF, HI=`rs_data` as latched. Latency is unchanged.
- `hi`/`lo` show the old values for the whole operation; partial results are never visible.
- `start` while `busy`=1 is ignored for every op, including MTHI/MTLO. The operation in flight is undisturbed.
- Reset:
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
  - Reset mid-operation abandons it: no `done`, and HI/LO are cleared.
  - Reset takes priority over `start` in the same cycle.

## Timing
- Arithmetic op with `start` in cycle 0 (IDLE):
  - `busy`=1 in cycles 1–33.
  - CALC occupies cycles 1–32; FIX occupies cycle 33.
  - In cycle 34: `busy`=0, `done`=1, and `hi`/`lo` are updated.
  - Latency is 34 cycles, independent of operand values.
- Back-to-back: a `start` in cycle 34 is accepted, because `busy`=0 there. The next result arrives in cycle 68.
- MTHI/MTLO: `hi`/`lo` change in the cycle after `start`. `done` stays 0.
- `done` is registered, lasts exactly one cycle, and is deasserted in every other cycle.
- `busy` is registered and glitch-free. It is derived from state (not IDLE).

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF at cycle 0:
  - `busy` high in cycles 1–33.
  - `done` in cycle 34 with HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (−3) × 0x00000007: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULT 0x80000000 × 0x80000000: HI=0x40000000, LO=0x00000000.
- DIV 0xFFFFFFF9 (−7) / 0x00000002: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- DIVU 0x00000064 / 0x00000007: LO=0x0000000E, HI=0x00000002.
- DIVU 0x12345678 / 0: LO=0xFFFFFFFF, HI=0x12345678, `done` in cycle 34.
- Busy interference: start DIVU 100/7. In cycle 5, pulse `start` with MTHI 0xAAAAAAAA; in cycle 6, pulse `start` with MULTU.
  - Required: both are ignored, and the DIVU result appears in cycle 34.
  - A subsequent idle MTHI 0xAAAAAAAA sets HI=0xAAAAAAAA one cycle later with no `done`.
- Reset mid-op: start MULTU 5×5 after loading HI=LO=0x11111111 via MTHI/MTLO; assert `rst` in cycle 10.
  - Required: from cycle 11, `busy`=0, `hi`=`lo`=0, and `done` never pulses.
  - A new MULTU 5×5 started in cycle 12 yields LO=0x19, HI=0 in cycle 46.
